// File: rtl/tlc_pkg.sv
// Shared lamp encodings, phase/state enums, default timing and arbitration helpers
// for the intersection phase scheduler.
package tlc_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [1:0] {
    PH_MAIN = 2'd0,
    PH_TURN = 2'd1,
    PH_SIDE = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  localparam int unsigned DEF_MIN_GREEN = 7;
  localparam int unsigned DEF_MAX_GREEN = 20;
  localparam int unsigned DEF_YELLOW    = 3;
  localparam int unsigned DEF_ALL_RED   = 2;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic [2:0] lamp_for(state_t st, logic member);
    logic [2:0] l;
    l = LAMP_RED;
    if (member && st == ST_GREEN)  l = LAMP_GRN;
    if (member && st == ST_YELLOW) l = LAMP_YEL;
    return l;
  endfunction

  // Walk k = 3,2,1 so the nearest pending phase after cur (k = 1) wins.
  function automatic phase_t rr_pick(phase_t cur, logic [2:0] pend);
    phase_t      sel;
    int unsigned idx;
    logic [1:0]  i2;
    sel = PH_MAIN;
    for (int unsigned k = 3; k >= 1; k--) begin
      idx = (32'(cur) + k) % 3;
      i2  = idx[1:0];
      if (pend[i2]) sel = phase_t'(i2);
    end
    return sel;
  endfunction

endpackage

// File: rtl/tlc_dwell_timer.sv
// Saturating dwell counter: loads 1 on restart, otherwise counts up to LIMIT while enabled.
module tlc_dwell_timer #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned LIMIT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (restart) begin
      count <= WIDTH'(1);
    end else if (enable && (count < WIDTH'(LIMIT))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Intersection phase scheduler: round-robin arbitration of detector requests and
// green/yellow/all-red sequencing. Emergency preemption is enabled by `TLC_PREEMPT_EN.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
  parameter int unsigned YELLOW    = DEF_YELLOW,
  parameter int unsigned ALL_RED   = DEF_ALL_RED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       emerg_req,
  input  logic [1:0] emerg_phase,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [1:0] phase,
  output logic       grant
);

  // Counter is sized for the longest state so yellow/all-red never saturate early.
  localparam int unsigned CNT_MAX = max3(MAX_GREEN, YELLOW, ALL_RED);
  localparam int unsigned DW      = $clog2(CNT_MAX + 1);

  state_t          state, state_nx;
  phase_t          phase_q, phase_nx;
  logic [2:0]      pending, pending_nx;
  logic            grant_nx;
  logic [DW-1:0]   dwell;
  logic [31:0]     dwell_ext;
  logic            own_req, others_wait, green_exit;
  logic            emerg_valid;
  phase_t          emerg_sel;

`ifdef TLC_PREEMPT_EN
  assign emerg_valid = emerg_req && (emerg_phase != 2'd3);
  assign emerg_sel   = phase_t'(emerg_phase);
`else
  logic unused_emerg;
  assign unused_emerg = ^{emerg_req, emerg_phase};
  assign emerg_valid  = 1'b0;
  assign emerg_sel    = PH_MAIN;
`endif

  assign dwell_ext = 32'(dwell);
  assign phase     = phase_q;

  tlc_dwell_timer #(
    .WIDTH (DW),
    .LIMIT (CNT_MAX)
  ) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .restart (state_nx != state),
    .enable  (1'b1),
    .count   (dwell)
  );

  always_comb begin
    own_req = 1'b0;
    case (phase_q)
      PH_MAIN: own_req = req[0];
      PH_TURN: own_req = req[1];
      PH_SIDE: own_req = req[2];
      default: own_req = 1'b0;
    endcase
    // MAIN is the rest phase: it only yields when someone else is waiting.
    others_wait = (phase_q == PH_MAIN) ? (pending[1] | pending[2]) : 1'b1;
    green_exit  = others_wait &&
                  (((dwell_ext >= MIN_GREEN) && !own_req) || (dwell_ext >= MAX_GREEN));
    if (emerg_valid) green_exit = (phase_q != emerg_sel);
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase_q;
    grant_nx = 1'b0;
    case (state)
      ST_ALLRED: begin
        if (dwell_ext >= ALL_RED) begin
          state_nx = ST_GREEN;
          phase_nx = emerg_valid ? emerg_sel : rr_pick(phase_q, pending);
          grant_nx = 1'b1;
        end
      end
      ST_GREEN: begin
        if (green_exit) state_nx = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (dwell_ext >= YELLOW) state_nx = ST_ALLRED;
      end
      default: state_nx = ST_ALLRED;
    endcase
  end

  always_comb begin
    pending_nx = pending;
    for (int unsigned p = 0; p < 3; p++) begin
      if (req[p] && !((state == ST_GREEN) && (32'(phase_q) == p))) pending_nx[p] = 1'b1;
      if (grant_nx && (32'(phase_nx) == p)) pending_nx[p] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_ALLRED;
      phase_q  <= PH_MAIN;
      pending  <= '0;
      grant    <= 1'b0;
      light_M1 <= LAMP_RED;
      light_M2 <= LAMP_RED;
      light_MT <= LAMP_RED;
      light_S  <= LAMP_RED;
    end else begin
      state    <= state_nx;
      phase_q  <= phase_nx;
      pending  <= pending_nx;
      grant    <= grant_nx;
      light_M1 <= lamp_for(state_nx, (phase_nx == PH_MAIN) || (phase_nx == PH_TURN));
      light_M2 <= lamp_for(state_nx, phase_nx == PH_MAIN);
      light_MT <= lamp_for(state_nx, phase_nx == PH_TURN);
      light_S  <= lamp_for(state_nx, phase_nx == PH_SIDE);
    end
  end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Self-checking bench for tlc_phase_scheduler: directed scenarios plus randomized
// requests compared cycle by cycle against a behavioural model of the phase rules.
module tb_tlc_phase_scheduler;

  localparam int MIN_G = 7;
  localparam int MAX_G = 20;
  localparam int YEL   = 3;
  localparam int AR    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       emerg_req = 1'b0;
  logic [1:0] emerg_phase = 2'd0;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [1:0] phase;
  logic       grant;
  logic [14:0] obs;

  int checks = 0;
  int errors = 0;

  tlc_phase_scheduler #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .YELLOW    (YEL),
    .ALL_RED   (AR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .emerg_req   (emerg_req),
    .emerg_phase (emerg_phase),
    .light_M1    (light_M1),
    .light_M2    (light_M2),
    .light_MT    (light_MT),
    .light_S     (light_S),
    .phase       (phase),
    .grant       (grant)
  );

  always #5 clk = ~clk;

  assign obs = {light_M1, light_M2, light_MT, light_S, phase, grant};

  // Model: segment 0 = clearance, 1 = green, 2 = yellow; m_t = seconds spent in segment.
  int       m_seg, m_t, m_ph;
  bit [2:0] m_pend;
  bit       m_grant;

  task automatic model_reset();
    m_seg = 0; m_t = 0; m_ph = 0; m_pend = '0; m_grant = 1'b0;
  endtask

  function automatic bit emerg_on();
`ifdef TLC_PREEMPT_EN
    return emerg_req && (emerg_phase != 2'd3);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int rr_next();
    int q;
    for (int k = 1; k <= 3; k++) begin
      q = (m_ph + k) % 3;
      if (m_pend[q[1:0]]) return q;
    end
    return 0;
  endfunction

  task automatic model_step();
    bit [2:0] np;
    int nseg, nph, e;
    bit done, ev, ngrant;
    if (!rst) begin
      model_reset();
      return;
    end
    ev = emerg_on();
    e  = int'(emerg_phase);
    np = m_pend;
    for (int p = 0; p < 3; p++)
      if (req[p[1:0]] && !(m_seg == 1 && m_ph == p)) np[p[1:0]] = 1'b1;
    nseg = m_seg; nph = m_ph; ngrant = 1'b0; done = 1'b0;
    case (m_seg)
      0: if (m_t >= AR) begin
           nph = ev ? e : rr_next();
           nseg = 1; np[nph[1:0]] = 1'b0; ngrant = 1'b1;
         end
      1: begin
           if (m_ph == 0) done = (m_pend[1] | m_pend[2]) && ((m_t >= MIN_G && !req[0]) || m_t >= MAX_G);
           else           done = (m_t >= MIN_G && !req[m_ph[1:0]]) || m_t >= MAX_G;
           if (ev) done = (m_ph != e);
           if (done) nseg = 2;
         end
      default: if (m_t >= YEL) nseg = 0;
    endcase
    m_t = (nseg != m_seg) ? 1 : ((m_t < 1000) ? m_t + 1 : m_t);
    m_seg = nseg; m_ph = nph; m_pend = np; m_grant = ngrant;
  endtask

  function automatic logic [14:0] exp_vec();
    logic [2:0] on, r;
    r  = 3'b100;
    on = (m_seg == 1) ? 3'b001 : (m_seg == 2) ? 3'b010 : 3'b100;
    return {(m_ph != 2) ? on : r, (m_ph == 0) ? on : r, (m_ph == 1) ? on : r,
            (m_ph == 2) ? on : r, m_ph[1:0], m_grant};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; emerg_req = 1'b0; emerg_phase = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic advance_to_main_dwell(input int n, output bit found);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (m_seg == 1 && m_ph == 0 && m_t == n) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [14:0] want;
    rst = 1'b1; #1; rst = 1'b0; #1;
    model_reset();
    checks++;
    if (obs !== 15'b100_100_100_100_00_0) begin
      errors++; $display("FAIL reset_async got=%b exp=%b", obs, 15'b100_100_100_100_00_0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      want = (i < 2)  ? 15'b100_100_100_100_00_0 :
             (i == 2) ? 15'b001_001_100_100_00_1 : 15'b001_001_100_100_00_0;
      checks++;
      if (obs !== want) begin
        errors++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, obs, want);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_rest_phase();
    int grants = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (grant) grants++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL rest_model cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    checks++;
    if (grants !== 0 || light_M1 !== 3'b001 || light_M2 !== 3'b001) begin
      errors++; $display("FAIL rest_hold grants=%0d M1=%b M2=%b exp 0/001/001", grants, light_M1, light_M2);
    end
  endtask

  task automatic test_side_call();
    bit found;
    int s_green = 0, m_yel = 0;
    do_reset();
    advance_to_main_dwell(10, found);
    checks++;
    if (!found || light_M1 !== 3'b001 || phase !== 2'd0) begin
      errors++; $display("FAIL side_reach found=%0d M1=%b phase=%0d exp 1/001/0", found, light_M1, phase);
    end
    req[2] = 1'b1;
    step();
    req[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (light_S === 3'b001) s_green++;
      if (light_M1 === 3'b010 && light_M2 === 3'b010) m_yel++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL side_model cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    checks++;
    if (s_green !== 7 || m_yel !== 3 || light_M1 !== 3'b001) begin
      errors++; $display("FAIL side_timing s_green=%0d m_yel=%0d M1=%b exp 7/3/001", s_green, m_yel, light_M1);
    end
  endtask

  task automatic test_max_green();
    bit found, turn_seen = 1'b0;
    int mg = 1;
    bit in_green = 1'b1;
    do_reset();
    advance_to_main_dwell(1, found);
    req = 3'b011;
    step();
    req = 3'b001;
    if (light_M1 === 3'b001 && light_M2 === 3'b001) mg++;
    for (int i = 0; i < 40 && in_green; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL maxg_model cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      if (light_M1 === 3'b001 && light_M2 === 3'b001) mg++;
      else in_green = 1'b0;
    end
    checks++;
    if (!found || mg !== MAX_G || light_M1 !== 3'b010) begin
      errors++; $display("FAIL maxg_dwell green=%0d M1=%b exp %0d/010", mg, light_M1, MAX_G);
    end
    for (int i = 0; i < 10 && !turn_seen; i++) begin
      step();
      if (light_MT === 3'b001) turn_seen = 1'b1;
    end
    checks++;
    if (!turn_seen || phase !== 2'd1 || grant !== 1'b1) begin
      errors++; $display("FAIL maxg_turn seen=%0d phase=%0d grant=%0d exp 1/1/1", turn_seen, phase, grant);
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    bit found;
    int order[$];
    do_reset();
    advance_to_main_dwell(3, found);
    req = 3'b110;
    step();
    req = 3'b000;
    for (int i = 0; i < 60; i++) begin
      step();
      if (grant === 1'b1) order.push_back(int'(phase));
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL rr_model cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    checks++;
    if (!found || order.size() < 3 || order[0] != 1 || order[1] != 2 || order[2] != 0) begin
      errors++; $display("FAIL rr_order n=%0d first=%0d,%0d,%0d exp 1,2,0", order.size(),
                         (order.size() > 0) ? order[0] : -1, (order.size() > 1) ? order[1] : -1,
                         (order.size() > 2) ? order[2] : -1);
    end
  endtask

  task automatic test_preempt();
    bit found;
    do_reset();
    advance_to_main_dwell(2, found);
    emerg_req = 1'b1; emerg_phase = 2'd2;
    step();
`ifdef TLC_PREEMPT_EN
    checks++;
    if (!found || light_M1 !== 3'b010) begin
      errors++; $display("FAIL preempt_yellow M1=%b exp 010", light_M1);
    end
`endif
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL preempt_model cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
`ifdef TLC_PREEMPT_EN
    checks++;
    if (light_S !== 3'b001 || phase !== 2'd2) begin
      errors++; $display("FAIL preempt_hold S=%b phase=%0d exp 001/2", light_S, phase);
    end
`else
    checks++;
    if (light_M1 !== 3'b001 || phase !== 2'd0) begin
      errors++; $display("FAIL preempt_ignored M1=%b phase=%0d exp 001/0", light_M1, phase);
    end
`endif
    emerg_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL preempt_release cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++) req[b] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) begin
        emerg_req   = ~emerg_req;
        emerg_phase = 2'($urandom_range(0, 3));
      end
      if (i == 750) begin
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 15'b100_100_100_100_00_0) begin
          errors++; $display("FAIL rand_async_reset got=%b exp=%b", obs, 15'b100_100_100_100_00_0);
        end
        model_reset();
        @(negedge clk);
        step();
        rst = 1'b1;
      end
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", i, obs, exp_vec());
      end
    end
    req = '0; emerg_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rest_phase();
    test_side_call();
    test_max_green();
    test_round_robin();
    test_preempt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlc_phase_scheduler.md
# tlc_phase_scheduler

Phase scheduler for the intersection traffic-light controller. It arbitrates vehicle-detector requests from the main (M1/M2), main-turn (MT) and side (S) approaches. It sequences green → yellow → all-red clearance with minimum and maximum green dwell times, and drives the four 3-bit lamp groups. MAIN is the rest phase. Timing is counted in `clk` cycles; the system clock is 1 Hz, so one cycle is one second.

## Interface
- `MIN_GREEN`, default 7: minimum green cycles per phase. Must be ≥1.
- `MAX_GREEN`, default 20: maximum green cycles when another phase is waiting. Must be ≥ MIN_GREEN.
- `YELLOW`, default 3: yellow cycles. Must be ≥1.
- `ALL_RED`, default 2: all-red clearance cycles. Must be ≥1.
- `clk  in  1`: system clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `req  in  3`: detector requests, synchronous to `clk`. [0]=MAIN, [1]=TURN, [2]=SIDE.
- `emerg_req  in  1`: emergency preemption request (see Configuration).
- `emerg_phase  in  2`: phase requested by preemption. Value 3 is invalid and ignored.
- `light_M1  out  3`: M1 lamp, one-hot {R,Y,G}. 3'b100=red, 3'b010=yellow, 3'b001=green.
- `light_M2  out  3`: M2 lamp, same encoding.
- `light_MT  out  3`: main-turn lamp, same encoding.
- `light_S  out  3`: side-road lamp, same encoding.
- `phase  out  2`: phase currently served (0 MAIN, 1 TURN, 2 SIDE). Holds its value through yellow and all-red.
- `grant  out  1`: one-cycle pulse on the first cycle of each green.

## Operation
- Phases and lamp sets:
  - MAIN: M1 and M2 green.
  - TURN: M1 and MT green.
  - SIDE: S green.
  - Lamps not in the active set are red.
  - During YELLOW, the lamps that were green show yellow.
- FSM states: ALLRED, GREEN, YELLOW.
  - Transitions: ALLRED → GREEN(next) → YELLOW → ALLRED.
- `pending[2:0]`:
  - Bit p is set when req[p]=1 and phase p is not currently in GREEN.
  - Bit p is cleared on the cycle phase p enters GREEN. Clear takes priority over set.
- Next-phase selection, taken at the end of ALLRED:
  - Round-robin over `pending`, starting at phase+1 and wrapping 2 → 0.
  - If nothing is pending, select MAIN.
- Leaving GREEN of MAIN:
  - Requires pending[1]|pending[2], and
  - either dwell ≥ MIN_GREEN with req[0]=0, or dwell = MAX_GREEN.
  - With nothing pending, MAIN holds green indefinitely. The dwell counter saturates at MAX_GREEN.
- Leaving GREEN of TURN or SIDE:
  - Either dwell ≥ MIN_GREEN with own req=0, or dwell = MAX_GREEN.
  - No waiting phase is needed, because the scheduler returns to MAIN.
- YELLOW lasts exactly YELLOW cycles, then goes to ALLRED.
- ALLRED lasts exactly ALL_RED cycles.

## Timing
- Dwell counter:
  - Loads 1 on the first cycle of each state and increments each cycle.
  - Width is $clog2(MAX_GREEN+1).
  - A state with duration D occupies exactly D cycles.
- Exit decisions are made from registered values. The next state becomes visible on the following edge.
- `req` to `pending` latency: 1 cycle.
- Lamp outputs are registered and change on the same edge as the state.
- Reset, asserted at any time including mid-operation:
  - All lamps 3'b100 immediately.
  - State ALLRED, phase=0, pending=0, grant=0, dwell=0.
- After reset release: ALL_RED cycles of all-red, then MAIN GREEN with grant=1.
- A request for phase p during YELLOW or ALLRED of phase p is kept pending. It is served on the next rotation.

## Configuration
- Macro: `TLC_PREEMPT_EN`.
- Defined:
  - emerg_req=1 with a valid emerg_phase=E forces the next selection to E.
  - GREEN of another phase exits to YELLOW on the next edge, ignoring MIN_GREEN.
  - YELLOW and ALLRED always complete their full durations.
  - GREEN of E holds while emerg_req=1. The dwell counter saturates.
  - On release, normal exit rules apply. Dwell already elapsed counts toward MIN_GREEN.
  - Preemption does not clear pending bits of other phases.
- Undefined: emerg_req and emerg_phase are ignored. The ports remain present and are unused.

## Structure
- Package `tlc_pkg`:
  - Lamp constants LAMP_RED, LAMP_YEL, LAMP_GRN.
  - Phase enum PH_MAIN, PH_TURN, PH_SIDE.
  - State enum ST_ALLRED, ST_GREEN, ST_YELLOW.
  - Default timing constants.
- One sub-module, `tlc_dwell_timer`:
  - Parameterised width.
  - Inputs: restart and enable.
  - Outputs: the saturating count.
- Arbitration, FSM and lamp decode live in the top module.

## Test plan
All scenarios use default parameters.
- **Reset:** rst=0 → all lamps 3'b100, phase=0. Release → 2 cycles all-red, then light_M1=light_M2=3'b001, grant=1 for one cycle.
- **Rest phase:** no req for 50 cycles → MAIN stays green and grant stays 0.
- **Side call:** 1-cycle req[2] at MAIN dwell 10 → 3 cycles M1/M2 yellow, 2 cycles all-red, light_S=3'b001. SIDE holds 7 cycles, then 3 yellow, 2 all-red, then MAIN.
- **Max green:** req[0] held high, req[1] asserted at MAIN dwell 1 → yellow begins after dwell 20, then TURN green.
- **Round robin:** req[1] and req[2] both pulsed during MAIN → TURN served first, SIDE next, then MAIN.
- **Preemption** (`TLC_PREEMPT_EN` defined): emerg_req=1 with emerg_phase=2 at MAIN dwell 2 → yellow on the next cycle. SIDE then holds green while emerg_req=1. Without the macro, MAIN is unaffected.
